// File: rtl/id_issue_queue.sv
// id_issue_queue
// DEPTH-entry FIFO between the decoder and the EX stage. It buffers the PC and
// an opaque decoded payload so the decoder can keep issuing while EX stalls.
// The stall and flush pipeline-control behaviour of the former single-entry
// ID/EX register is kept.
//
// Optional feature: define ID_ISSUE_QUEUE_PERF_EN to add two 16-bit saturating
// counters, perf_full_cycles and perf_flushes.
//
// DEPTH must be a power of two and at least 2. The pointers wrap modulo DEPTH
// through plain binary overflow.
module id_issue_queue #(
    parameter int PC_W      = 30,
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         in_en,
    input  logic [PC_W-1:0]              in_pc,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    output logic                         in_ready,
    output logic                         almost_full,
    output logic                         out_en,
    output logic [PC_W-1:0]              out_pc,
    output logic [PAYLOAD_W-1:0]         out_payload,
`ifdef ID_ISSUE_QUEUE_PERF_EN
    output logic [15:0]                  perf_full_cycles,
    output logic [15:0]                  perf_flushes,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(DEPTH - 1);

    logic [PC_W-1:0]      r_pc_mem [DEPTH];
    logic [PAYLOAD_W-1:0] r_pl_mem [DEPTH];
    logic [PTR_W-1:0]     r_wp;
    logic [PTR_W-1:0]     r_rp;
    logic [CNT_W-1:0]     r_cnt;

    logic w_full;
    logic w_nonempty;
    logic w_push;
    logic w_pop;

    // Ready and valid come only from registered occupancy. This keeps stall
    // and flush off any combinational path to in_ready.
    assign w_full     = (r_cnt == CNT_FULL);
    assign w_nonempty = (r_cnt != '0);
    assign w_push     = in_en & ~w_full & ~flush;
    assign w_pop      = w_nonempty & ~stall & ~flush;

    assign in_ready    = ~w_full;
    assign almost_full = (r_cnt >= CNT_AFULL);
    assign out_en      = w_nonempty;
    assign count       = r_cnt;

    // An empty queue presents a zero bubble to EX. Stale slots stay hidden.
    assign out_pc      = w_nonempty ? r_pc_mem[r_rp] : '0;
    assign out_payload = w_nonempty ? r_pl_mem[r_rp] : '0;

    // Pointer and occupancy update. Flush outranks push, pop and stall.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Entry storage. Reset clears every slot so nothing survives a reset.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i] <= '0;
                r_pl_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_mem[r_wp] <= in_pc;
            r_pl_mem[r_wp] <= in_payload;
        end
    end

`ifdef ID_ISSUE_QUEUE_PERF_EN
    logic [15:0] r_perf_full;
    logic [15:0] r_perf_flush;

    assign perf_full_cycles = r_perf_full;
    assign perf_flushes     = r_perf_flush;

    // Saturating event counters: cycles spent full, and flushes that
    // discarded live entries.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_perf_full  <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_full && (r_perf_full != 16'hFFFF)) begin
                r_perf_full <= r_perf_full + 16'd1;
            end
            if (flush && w_nonempty && (r_perf_flush != 16'hFFFF)) begin
                r_perf_flush <= r_perf_flush + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_issue_queue.sv
// Testbench for id_issue_queue (DEPTH=4). It runs directed scenarios and then
// random traffic. Both are checked against a queue-based reference model.
module tb_id_issue_queue;

    localparam int PC_W      = 30;
    localparam int PAYLOAD_W = 64;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                 clk;
    logic                 reset_;
    logic                 stall;
    logic                 flush;
    logic                 in_en;
    logic [PC_W-1:0]      in_pc;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_ready;
    logic                 almost_full;
    logic                 out_en;
    logic [PC_W-1:0]      out_pc;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [CNT_W-1:0]     count;
`ifdef ID_ISSUE_QUEUE_PERF_EN
    logic [15:0]          perf_full_cycles;
    logic [15:0]          perf_flushes;
`endif

    id_issue_queue #(.PC_W(PC_W), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .stall       (stall),
        .flush       (flush),
        .in_en       (in_en),
        .in_pc       (in_pc),
        .in_payload  (in_payload),
        .in_ready    (in_ready),
        .almost_full (almost_full),
        .out_en      (out_en),
        .out_pc      (out_pc),
        .out_payload (out_payload),
`ifdef ID_ISSUE_QUEUE_PERF_EN
        .perf_full_cycles (perf_full_cycles),
        .perf_flushes     (perf_flushes),
`endif
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0]      pc;
        logic [PAYLOAD_W-1:0] pl;
    } ent_t;

    ent_t mq[$];
    int   m_full_cycles;
    int   m_flushes;
    int   n_checks;
    int   n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = mq.size();
        chk("out_en", 64'(out_en), 64'(sz != 0));
        chk("count", 64'(count), 64'(sz));
        chk("in_ready", 64'(in_ready), 64'(sz != DEPTH));
        chk("almost_full", 64'(almost_full), 64'(sz >= DEPTH - 1));
        if (sz != 0) begin
            chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
            chk("out_payload", out_payload, mq[0].pl);
        end else begin
            chk("out_pc_bubble", 64'(out_pc), 64'd0);
            chk("out_payload_bubble", out_payload, 64'd0);
        end
    endtask

    // Called just after a falling edge. Drives one cycle of inputs, lets the
    // rising edge happen, updates the model, then checks at the next falling edge.
    task automatic step(input logic s, input logic f, input logic e,
                        input logic [PC_W-1:0] p, input logic [PAYLOAD_W-1:0] d);
        bit   m_push;
        bit   m_pop;
        ent_t ent;
        stall      = s;
        flush      = f;
        in_en      = e;
        in_pc      = p;
        in_payload = d;
        m_push = e && (mq.size() != DEPTH) && !f;
        m_pop  = (mq.size() != 0) && !s && !f;
        if (mq.size() == DEPTH && m_full_cycles < 16'hFFFF) m_full_cycles++;
        if (f && mq.size() != 0 && m_flushes < 16'hFFFF) m_flushes++;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                ent.pc = p;
                ent.pl = d;
                mq.push_back(ent);
            end
        end
        @(negedge clk);
        in_en = 1'b0;
        flush = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input logic s);
        step(s, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        mq.delete();
        m_full_cycles = 0;
        m_flushes     = 0;
        #1;
        check_outputs();
        @(negedge clk);
        reset_ = 1'b1;
        check_outputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_full_cycles = 0;
        m_flushes = 0;
        stall = 0; flush = 0; in_en = 0; in_pc = '0; in_payload = '0;
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        reset_ = 1'b1;
        @(negedge clk);
        check_outputs();

        // Single push flows straight through.
        step(1'b0, 1'b0, 1'b1, 30'h100, 64'hA5);
        chk("t1_pc", 64'(out_pc), 64'h100);
        chk("t1_payload", out_payload, 64'hA5);
        chk("t1_count", 64'(count), 64'd1);
        idle(1'b0);
        chk("t1_drained", 64'(out_en), 64'd0);

        // Fill under stall. The 5th push is refused. Then drain in order.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 30'(32'h10 + i), 64'(64'hB000 + i));
            if (i == 2) chk("t2_afull_at3", 64'(almost_full), 64'd1);
        end
        chk("t2_full_ready", 64'(in_ready), 64'd0);
        chk("t2_full_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_pc", 64'(out_pc), 64'(32'h10 + i));
            idle(1'b0);
        end
        chk("t2_empty", 64'(out_en), 64'd0);

        // Steady push and pop at occupancy 2, across pointer wraps.
        step(1'b1, 1'b0, 1'b1, 30'h20, 64'hC20);
        step(1'b1, 1'b0, 1'b1, 30'h21, 64'hC21);
        for (int i = 2; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, 30'(32'h20 + i), 64'(64'hC00 + 32'h20 + i));
            chk("t3_count", 64'(count), 64'd2);
        end
        idle(1'b0);
        idle(1'b0);

        // Flush at occupancy 3 drops both the queue and the incoming entry.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 30'(32'h2C + i), 64'(i));
        step(1'b1, 1'b1, 1'b1, 30'h30, 64'hD30);
        chk("t4_flush_count", 64'(count), 64'd0);
        chk("t4_flush_en", 64'(out_en), 64'd0);
        step(1'b1, 1'b0, 1'b1, 30'h31, 64'hD31);
        chk("t4_head", 64'(out_pc), 64'h31);
        idle(1'b0);

        // Asynchronous reset in the middle of a cycle.
        step(1'b1, 1'b0, 1'b1, 30'h40, 64'h1);
        step(1'b1, 1'b0, 1'b1, 30'h41, 64'h2);
        #2;
        reset_ = 1'b0;
        #1;
        chk("t5_async_en", 64'(out_en), 64'd0);
        chk("t5_async_count", 64'(count), 64'd0);
        do_reset();

`ifdef ID_ISSUE_QUEUE_PERF_EN
        chk("perf_full_reset", 64'(perf_full_cycles), 64'd0);
        chk("perf_flush_reset", 64'(perf_flushes), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 30'(32'h50 + i), 64'(i));
        for (int i = 0; i < 4; i++) idle(1'b1);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        chk("perf_full", 64'(perf_full_cycles), 64'd5);
        chk("perf_flush", 64'(perf_flushes), 64'd1);
`endif

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic s;
            logic f;
            logic e;
            s = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 40) == 0);
            e = ($urandom_range(0, 3) != 0);
            step(s, f, e, 30'($urandom), {$urandom, $urandom});
        end
`ifdef ID_ISSUE_QUEUE_PERF_EN
        chk("perf_full_rand", 64'(perf_full_cycles), 64'(m_full_cycles));
        chk("perf_flush_rand", 64'(perf_flushes), 64'(m_flushes));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_issue_queue.md
Name: id_issue_queue

Overview:
- Parametrised successor to the single-entry ID/EX pipeline register.
- Buffers up to DEPTH decoded instructions (PC plus an opaque decoded-payload bundle) between the decoder and the EX stage.
- Lets the decoder keep issuing while EX stalls, and keeps the existing stall/flush pipeline-control semantics.
- Sits inside the ID stage, fed by the decoder outputs, driving the id_* signals to EX.

Parameters:
- PC_W, 30, width of the instruction word address (WordAddrBus).
- PAYLOAD_W, 64, width of the packed decoded bundle (alu_op, alu_in, mem_op, ctrl_op, dst_addr, gpr_we_, exp_code, ...).
- DEPTH, 4, number of entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_  in  1  asynchronous reset, active-low.
- stall  in  1  EX stage stalled; head entry must be held.
- flush  in  1  discard all buffered and incoming entries.
- in_en  in  1  decoder presents a valid instruction.
- in_pc  in  PC_W  PC of the incoming instruction.
- in_payload  in  PAYLOAD_W  decoded bundle of the incoming instruction.
- in_ready  out  1  queue can accept an entry this cycle.
- almost_full  out  1  count >= DEPTH-1; decoder uses it to pre-throttle.
- out_en  out  1  head entry valid (id_en).
- out_pc  out  PC_W  head PC (id_pc).
- out_payload  out  PAYLOAD_W  head decoded bundle.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: DEPTH-entry register array with write pointer wp, read pointer rp and occupancy cnt. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Reset (reset_=0, asynchronous): wp=rp=0, cnt=0; all array entries cleared to 0.
  - Outputs during and after reset: out_en=0, out_pc=0, out_payload=0, in_ready=1, almost_full=0, count=0.
  - If reset asserts mid-operation, all entries are lost immediately and no partial state survives.
- in_ready = (cnt != DEPTH). It depends only on state; there is no combinational path from stall or flush.
- push = in_en & in_ready & ~flush. An in_en with in_ready=0 is ignored; the decoder must hold the instruction.
- pop = out_en & ~stall & ~flush.
- out_en = (cnt != 0). When cnt=0, out_pc and out_payload are forced to 0, so EX sees a NOP bubble.
- Outputs are driven from the array head. Latency is 1 cycle: an entry pushed at edge N appears at the outputs after edge N when the queue was empty.
- Cycle update when flush=0:
  - push only: entry[wp] <= {in_pc,in_payload}; wp+1; cnt+1.
  - pop only: rp+1; cnt-1.
  - push and pop together: both pointers advance; cnt unchanged. This is legal whenever 0<cnt<DEPTH.
  - Full (cnt=DEPTH) with pop: push is refused that cycle, because in_ready was 0 at cycle start.
- flush=1: takes priority over push, pop and stall.
  - Next edge: wp=rp=0, cnt=0, out_en=0.
  - The in_en instruction in the flush cycle is discarded.
  - Stale array contents are don't-care but are not visible, because of output forcing.
- Order is strictly FIFO; no entry is duplicated or skipped across pointer wrap.
- count is registered: it equals cnt after each edge.

Optional Feature:
- Macro: ID_ISSUE_QUEUE_PERF_EN.
- Defined: adds two outputs, perf_full_cycles and perf_flushes, each 16 bits. Both clear on reset and saturate at 16'hFFFF.
  - perf_full_cycles increments every cycle with cnt==DEPTH.
  - perf_flushes increments every cycle flush=1 while cnt!=0.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan (DEPTH=4, PC_W=30, PAYLOAD_W=64):
- Reset, then push pc=0x100 with payload=0xA5 in one cycle, stall=0 → next cycle out_en=1, out_pc=0x100, out_payload=0xA5, count=1; the cycle after, out_en=0, out_pc=0, count=0.
- Hold stall=1 and push pc 0x10,0x11,0x12,0x13 → count reaches 4, almost_full=1 at count 3, in_ready=0 at 4; a 5th in_en (0x14) is ignored. Release stall → outputs 0x10,0x11,0x12,0x13 on consecutive cycles, with in_ready=1 from the cycle count=3.
- Continuous push and pop for 10 cycles at count=2 (pc 0x20..0x29) → count stays 2; outputs appear in exact order across two pointer wraps.
- At count=3, assert flush together with in_en pc=0x30 → next cycle count=0, out_en=0; 0x30 never appears; a later push of 0x31 emerges as the head.
- Assert reset_=0 asynchronously mid-cycle at count=2 → out_en=0 and count=0 immediately, before the next clock edge.
- With ID_ISSUE_QUEUE_PERF_EN defined: hold full for 5 cycles, then flush once → perf_full_cycles=5, perf_flushes=1.
